// File: rtl/store_write_buffer_if.sv
// Retire, D-cache write and completion signals of the store write buffer.
// STORE_WB_FWD_EN adds the load lookup signals.
interface store_write_buffer_if #(
    parameter int N_WAY    = 2,
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 8,
    parameter int SQ_POS_W = 4
);
    localparam int CW = $clog2(WB_DEPTH) + 1;

    logic [N_WAY-1:0]          ret_valid;
    logic [N_WAY*XLEN-1:0]     ret_addr;
    logic [N_WAY*XLEN-1:0]     ret_data;
    logic [N_WAY*2-1:0]        ret_size;
    logic [N_WAY*SQ_POS_W-1:0] ret_pos;
    logic [CW-1:0]             wb_free;
    logic                      wb_empty;
    logic                      mem_req_valid;
    logic [XLEN-1:0]           mem_req_addr;
    logic [XLEN-1:0]           mem_req_data;
    logic [3:0]                mem_req_be;
    logic                      mem_req_ready;
    logic                      done_valid;
    logic [SQ_POS_W-1:0]       done_pos;
    logic                      overflow;
`ifdef STORE_WB_FWD_EN
    logic                      ld_valid;
    logic [XLEN-1:0]           ld_addr;
    logic [1:0]                ld_size;
    logic                      ld_hit;
    logic [XLEN-1:0]           ld_data;
`endif

    modport slave (
`ifdef STORE_WB_FWD_EN
        input  ld_valid, ld_addr, ld_size,
        output ld_hit, ld_data,
`endif
        input  ret_valid, ret_addr, ret_data, ret_size, ret_pos,
        input  mem_req_ready,
        output wb_free, wb_empty, overflow,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
        output done_valid, done_pos
    );

    modport master (
`ifdef STORE_WB_FWD_EN
        output ld_valid, ld_addr, ld_size,
        input  ld_hit, ld_data,
`endif
        output ret_valid, ret_addr, ret_data, ret_size, ret_pos,
        output mem_req_ready,
        input  wb_free, wb_empty, overflow,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
        input  done_valid, done_pos
    );
endinterface

// File: rtl/store_write_buffer.sv
// In-order retired-store buffer draining one write per cycle to the D-cache.
// Define STORE_WB_FWD_EN to add the combinational store-to-load lookup port.
module store_write_buffer #(
    parameter int N_WAY    = 2,
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 8,
    parameter int SQ_POS_W = 4
) (
    input logic                 clock,
    input logic                 reset,
    store_write_buffer_if.slave bus_io
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    function automatic logic [3:0] be_of(
        input logic [1:0] sz,
        input logic [1:0] a
    );
        unique case (1'b1)
            sz == 2'd0: be_of = 4'b0001 << a;
            sz == 2'd1: be_of = a[1] ? 4'b1100 : 4'b0011;
            default:    be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] data_of(
        input logic [1:0]      sz,
        input logic [1:0]      a,
        input logic [XLEN-1:0] d
    );
        unique case (1'b1)
            sz == 2'd0:
                data_of = {{(XLEN-8){1'b0}}, d[7:0]} << {a, 3'b000};
            sz == 2'd1:
                data_of = {{(XLEN-16){1'b0}}, d[15:0]} << {a[1], 4'b0000};
            default:
                data_of = d;
        endcase
    endfunction

    // Entries are stored already shaped for the cache write port.
    logic [XLEN-1:0]     waddr_q [WB_DEPTH];
    logic [XLEN-1:0]     wdata_q [WB_DEPTH];
    logic [3:0]          wbe_q   [WB_DEPTH];
    logic [SQ_POS_W-1:0] pos_q   [WB_DEPTH];

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       free_q;
    logic [0:0]          state_q, state_d;
    logic                ovf_q, ovf_d;
    logic                done_v_q;
    logic [SQ_POS_W-1:0] done_pos_q;

    logic                req_valid;
    logic                hs;
    logic [N_WAY-1:0]    acc;
    logic [PW-1:0]       slot [N_WAY];
    logic [CW-1:0]       free_now;
    logic [CW-1:0]       n_acc;

    assign req_valid = (state_q == ISSUE);
    assign hs        = req_valid && bus_io.mem_req_ready;

    // A slot drained this cycle is not reusable until the next one.
    always_comb begin
        free_now = CW'(WB_DEPTH) - count_q;
        n_acc    = '0;
        acc      = '0;
        ovf_d    = ovf_q;
        for (int l = 0; l < N_WAY; l++) begin
            slot[l] = tail_q + n_acc[PW-1:0];
            if (bus_io.ret_valid[l]) begin
                if (n_acc < free_now) begin
                    acc[l] = 1'b1;
                    n_acc  = n_acc + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(hs);
        tail_d  = tail_q + n_acc[PW-1:0];
        count_d = count_q + n_acc - CW'(hs);
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_d != '0) state_d = ISSUE;
            ISSUE:   if (hs && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            free_q     <= CW'(WB_DEPTH);
            state_q    <= IDLE;
            ovf_q      <= 1'b0;
            done_v_q   <= 1'b0;
            done_pos_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            free_q     <= CW'(WB_DEPTH) - count_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            done_v_q   <= hs;
            done_pos_q <= hs ? pos_q[head_q] : '0;
        end
    end

    always_ff @(posedge clock) begin
        for (int l = 0; l < N_WAY; l++) begin
            if (acc[l]) begin
                waddr_q[slot[l]] <=
                    {bus_io.ret_addr[l*XLEN+2 +: XLEN-2], 2'b00};
                wdata_q[slot[l]] <= data_of(
                    bus_io.ret_size[l*2 +: 2],
                    bus_io.ret_addr[l*XLEN +: 2],
                    bus_io.ret_data[l*XLEN +: XLEN]);
                wbe_q[slot[l]] <= be_of(
                    bus_io.ret_size[l*2 +: 2],
                    bus_io.ret_addr[l*XLEN +: 2]);
                pos_q[slot[l]] <= bus_io.ret_pos[l*SQ_POS_W +: SQ_POS_W];
            end
        end
    end

    assign bus_io.mem_req_valid = req_valid;
    assign bus_io.mem_req_addr  = req_valid ? waddr_q[head_q] : '0;
    assign bus_io.mem_req_data  = req_valid ? wdata_q[head_q] : '0;
    assign bus_io.mem_req_be    = req_valid ? wbe_q[head_q] : '0;
    assign bus_io.wb_free       = free_q;
    assign bus_io.wb_empty      = (count_q == '0) && !req_valid;
    assign bus_io.overflow      = ovf_q;
    assign bus_io.done_valid    = done_v_q;
    assign bus_io.done_pos      = done_pos_q;

`ifdef STORE_WB_FWD_EN
    logic [3:0]      ld_be;
    logic [1:0]      ld_off;
    logic [XLEN-1:0] ld_mask;
    logic [XLEN-1:0] ld_word;
    logic [PW-1:0]   idx;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [XLEN-1:0] fwd_shift;

    always_comb begin
        ld_be   = be_of(bus_io.ld_size, bus_io.ld_addr[1:0]);
        ld_word = {bus_io.ld_addr[XLEN-1:2], 2'b00};
        unique case (1'b1)
            bus_io.ld_size == 2'd0: begin
                ld_off  = bus_io.ld_addr[1:0];
                ld_mask = XLEN'(32'hFF);
            end
            bus_io.ld_size == 2'd1: begin
                ld_off  = {bus_io.ld_addr[1], 1'b0};
                ld_mask = XLEN'(32'hFFFF);
            end
            default: begin
                ld_off  = 2'd0;
                ld_mask = '1;
            end
        endcase
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        // Oldest to newest: the last overlapping entry decides.
        for (int j = 0; j < WB_DEPTH; j++) begin
            idx = head_q + PW'(j);
            if (CW'(j) < count_q && waddr_q[idx] == ld_word &&
                (wbe_q[idx] & ld_be) != 4'b0000) begin
                fwd_hit  = (wbe_q[idx] & ld_be) == ld_be;
                fwd_data = wdata_q[idx];
            end
        end
        fwd_shift = (fwd_data >> {ld_off, 3'b000}) & ld_mask;
    end

    assign bus_io.ld_hit  = bus_io.ld_valid && fwd_hit;
    assign bus_io.ld_data = bus_io.ld_hit ? fwd_shift : '0;
`endif
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed and randomized bench for store_write_buffer against a queue model.
// STORE_WB_FWD_EN also checks the load lookup port.
module tb_store_write_buffer;
    localparam int N_WAY    = 2;
    localparam int XLEN     = 32;
    localparam int WB_DEPTH = 8;
    localparam int SQ_POS_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    store_write_buffer_if #(
        .N_WAY(N_WAY), .XLEN(XLEN),
        .WB_DEPTH(WB_DEPTH), .SQ_POS_W(SQ_POS_W)
    ) bus_io ();

    store_write_buffer #(
        .N_WAY(N_WAY), .XLEN(XLEN),
        .WB_DEPTH(WB_DEPTH), .SQ_POS_W(SQ_POS_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus_io.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  pos;
    } st_t;

    st_t        q[$];
    bit         m_ovf;
    bit         m_done;
    logic [3:0] m_dpos;
    int         errs = 0;
    int         checks = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Byte-lane view: nb bytes starting at the naturally aligned offset.
    function automatic void shape(
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [1:0]  sz,
        output logic [3:0]  be,
        output logic [31:0] wd
    );
        int nb;
        int off;
        nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        off = (int'(a[1:0]) / nb) * nb;
        be  = '0;
        wd  = '0;
        for (int b = 0; b < nb; b++) begin
            be[off+b]          = 1'b1;
            wd[8*(off+b) +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic lane(int l, bit v, logic [31:0] a, logic [31:0] d,
                        logic [1:0] s, logic [3:0] p);
        bus_io.ret_valid[l]         = v;
        bus_io.ret_addr[l*32 +: 32] = a;
        bus_io.ret_data[l*32 +: 32] = d;
        bus_io.ret_size[l*2 +: 2]   = s;
        bus_io.ret_pos[l*4 +: 4]    = p;
    endtask

    task automatic check_all();
        logic [3:0]  be;
        logic [31:0] wd;
        chk("wb_free", bus_io.wb_free, WB_DEPTH - q.size());
        chk("wb_empty", bus_io.wb_empty, q.size() == 0);
        chk("overflow", bus_io.overflow, m_ovf);
        chk("req_valid", bus_io.mem_req_valid, q.size() != 0);
        if (q.size() != 0) begin
            shape(q[0].addr, q[0].data, q[0].size, be, wd);
            chk("req_addr", bus_io.mem_req_addr, q[0].addr & ~32'h3);
            chk("req_be", bus_io.mem_req_be, be);
            chk("req_data", bus_io.mem_req_data, wd);
        end else begin
            chk("req_addr0", bus_io.mem_req_addr, 0);
            chk("req_be0", bus_io.mem_req_be, 0);
            chk("req_data0", bus_io.mem_req_data, 0);
        end
        chk("done_valid", bus_io.done_valid, m_done);
        if (m_done) chk("done_pos", bus_io.done_pos, m_dpos);
`ifdef STORE_WB_FWD_EN
        begin
            bit          h;
            int          nb;
            logic [31:0] dd;
            logic [3:0]  lbe;
            logic [3:0]  ebe;
            logic [31:0] ed;
            logic [31:0] unused;
            h  = 0;
            dd = '0;
            shape(bus_io.ld_addr, 32'h0, bus_io.ld_size, lbe, unused);
            foreach (q[i]) begin
                shape(q[i].addr, q[i].data, q[i].size, ebe, ed);
                if ((q[i].addr >> 2) == (bus_io.ld_addr >> 2) &&
                    (ebe & lbe) != 0) begin
                    h  = (ebe & lbe) == lbe;
                    dd = '0;
                    nb = 0;
                    for (int b = 0; b < 4; b++) begin
                        if (lbe[b]) begin
                            dd[8*nb +: 8] = ed[8*b +: 8];
                            nb++;
                        end
                    end
                end
            end
            h = h && bus_io.ld_valid;
            if (!h) dd = '0;
            chk("ld_hit", bus_io.ld_hit, h);
            chk("ld_data", bus_io.ld_data, dd);
        end
`endif
    endtask

    // Apply current inputs for one edge, advance the model, then check.
    task automatic step(bit rst);
        int  free_n;
        int  rank;
        bit  hs;
        st_t e;
        reset = rst;
        if (rst) begin
            q.delete();
            m_ovf  = 0;
            m_done = 0;
            m_dpos = '0;
        end else begin
            free_n = WB_DEPTH - q.size();
            hs     = (q.size() != 0) && bus_io.mem_req_ready;
            m_done = hs;
            m_dpos = hs ? q[0].pos : 4'd0;
            rank   = 0;
            for (int l = 0; l < N_WAY; l++) begin
                if (bus_io.ret_valid[l]) begin
                    if (rank < free_n) begin
                        e.addr = bus_io.ret_addr[l*32 +: 32];
                        e.data = bus_io.ret_data[l*32 +: 32];
                        e.size = bus_io.ret_size[l*2 +: 2];
                        e.pos  = bus_io.ret_pos[l*4 +: 4];
                        q.push_back(e);
                        rank++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (hs) void'(q.pop_front());
        end
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle_lanes();
        for (int l = 0; l < N_WAY; l++) lane(l, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus_io.mem_req_ready = 1'b0;
        idle_lanes();
`ifdef STORE_WB_FWD_EN
        bus_io.ld_valid = 1'b0;
        bus_io.ld_addr  = '0;
        bus_io.ld_size  = '0;
`endif
        step(1);
        chk("rst_free", bus_io.wb_free, 8);
        chk("rst_empty", bus_io.wb_empty, 1);

        // Single byte store, shaped and completed.
        bus_io.mem_req_ready = 1'b1;
        lane(0, 1, 32'h1003, 32'hAB, 2'd0, 4'd3);
        step(0);
        chk("t1_addr", bus_io.mem_req_addr, 32'h1000);
        chk("t1_be", bus_io.mem_req_be, 4'b1000);
        chk("t1_data", bus_io.mem_req_data, 32'hAB00_0000);
        idle_lanes();
        step(0);
        chk("t1_done", bus_io.done_valid, 1);
        chk("t1_pos", bus_io.done_pos, 3);

        // Fill with ready low, overflow by one, then drain.
        step(1);
        bus_io.mem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            lane(0, 1, 32'h100 + 8*c, 32'h1111 * c, 2'd2, 4'(2*c + 1));
            lane(1, 1, 32'h104 + 8*c, 32'h2222 * c, 2'd2, 4'(2*c + 2));
            step(0);
            chk("fill_free", bus_io.wb_free, 6 - 2*c);
            chk("fill_ovf", bus_io.overflow, 0);
        end
        idle_lanes();
        lane(0, 1, 32'h200, 32'h99, 2'd2, 4'd9);
        step(0);
        chk("full_ovf", bus_io.overflow, 1);
        chk("full_free", bus_io.wb_free, 0);
        idle_lanes();
        bus_io.mem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0);
            chk("drain_done", bus_io.done_valid, 1);
            chk("drain_pos", bus_io.done_pos, i + 1);
        end
        step(0);
        chk("ovf_sticky", bus_io.overflow, 1);
        step(1);
        chk("ovf_clear", bus_io.overflow, 0);

        // Half-word held stable while ready is low.
        bus_io.mem_req_ready = 1'b0;
        lane(0, 1, 32'h2002, 32'h1234, 2'd1, 4'd5);
        step(0);
        idle_lanes();
        for (int i = 0; i < 4; i++) begin
            bus_io.mem_req_ready = (i == 3);
            chk("half_be", bus_io.mem_req_be, 4'b1100);
            chk("half_data", bus_io.mem_req_data, 32'h1234_0000);
            chk("half_addr", bus_io.mem_req_addr, 32'h2000);
            step(0);
        end
        chk("half_done", bus_io.done_pos, 5);

        // Reset while issuing drops everything in flight.
        bus_io.mem_req_ready = 1'b0;
        lane(0, 1, 32'h300, 32'h1, 2'd2, 4'd1);
        lane(1, 1, 32'h304, 32'h2, 2'd2, 4'd2);
        step(0);
        lane(1, 0, 0, 0, 0, 0);
        step(0);
        idle_lanes();
        bus_io.mem_req_ready = 1'b1;
        step(1);
        chk("rst_valid", bus_io.mem_req_valid, 0);
        chk("rst_free8", bus_io.wb_free, 8);
        chk("rst_nodone", bus_io.done_valid, 0);
        step(0);

`ifdef STORE_WB_FWD_EN
        bus_io.mem_req_ready = 1'b0;
        lane(0, 1, 32'h40, 32'hDEAD_BEEF, 2'd2, 4'd7);
        step(0);
        idle_lanes();
        bus_io.ld_valid = 1'b1;
        bus_io.ld_addr  = 32'h41;
        bus_io.ld_size  = 2'd0;
        #1;
        chk("fwd_hit", bus_io.ld_hit, 1);
        chk("fwd_data", bus_io.ld_data, 32'hBE);
        bus_io.ld_addr = 32'h44;
        bus_io.ld_size = 2'd2;
        #1;
        chk("fwd_miss", bus_io.ld_hit, 0);
        bus_io.ld_valid = 1'b0;
        step(1);
`endif

        // Random traffic with occasional overflow attempts and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [N_WAY-1:0] v;
            int               fr;
            bus_io.mem_req_ready = ($urandom_range(0, 3) != 0);
            v  = N_WAY'($urandom);
            fr = WB_DEPTH - q.size();
            if ($urandom_range(0, 19) != 0) begin
                for (int l = N_WAY - 1; l >= 0; l--)
                    if ($countones(v) > fr) v[l] = 1'b0;
            end
            for (int l = 0; l < N_WAY; l++)
                lane(l, v[l], 32'h40 + $urandom_range(0, 31),
                     $urandom, 2'($urandom_range(0, 2)),
                     4'($urandom_range(1, 15)));
`ifdef STORE_WB_FWD_EN
            bus_io.ld_valid = $urandom_range(0, 1);
            bus_io.ld_addr  = 32'h40 + $urandom_range(0, 31);
            bus_io.ld_size  = 2'($urandom_range(0, 2));
`endif
            step($urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits between the store queue retire port and the D-cache write port.
- Accepts up to N_WAY retired stores per cycle and holds them in an in-order FIFO.
- Drains one store per cycle to the D-cache over a valid/ready handshake, and returns a one-cycle completion (store position) to the store queue so it can free the slot.
- Retired stores are architecturally committed, so the block has no flush input; it empties only by draining or by reset.

Parameters:
N_WAY, 2, retire lanes per cycle; lane 0 is oldest
XLEN, 32, address/data width
WB_DEPTH, 8, FIFO entries; power of two, >= N_WAY
SQ_POS_W, 4, width of store position tag (1-based; 0 = none)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
ret_valid  in  N_WAY  retired store valid per lane
ret_addr  in  N_WAY*XLEN  byte address per lane
ret_data  in  N_WAY*XLEN  store data per lane, right-aligned
ret_size  in  N_WAY*2  0=BYTE 1=HALF 2=WORD
ret_pos  in  N_WAY*SQ_POS_W  store queue position
wb_free  out  $clog2(WB_DEPTH)+1  free entries, registered
wb_empty  out  1  FIFO empty and no request outstanding
mem_req_valid  out  1  write request valid
mem_req_addr  out  XLEN  word-aligned address (low 2 bits 0)
mem_req_data  out  XLEN  lane-shifted write data
mem_req_be  out  4  byte enables
mem_req_ready  in  1  D-cache accepts request
done_valid  out  1  store completed (one-cycle pulse)
done_pos  out  SQ_POS_W  position of completed store
overflow  out  1  sticky: enqueue attempted with no free slot

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values (also applied on reset mid-operation, which drops any in-flight request):
  - wb_free=WB_DEPTH, wb_empty=1, overflow=0.
  - mem_req_valid=0, done_valid=0; all data outputs 0.
  - head=tail=count=0; FSM in IDLE.
- Enqueue:
  - Valid lanes are compacted in lane order; lane 0 is written first, at tail.
  - k valid lanes advance tail by k modulo WB_DEPTH.
  - Lanes beyond current free space are dropped and overflow is set; it stays set until reset.
  - Producer contract: sum(ret_valid) <= wb_free.
- FSM states:
  - IDLE: mem_req_valid=0. Moves to ISSUE when count != 0 at a clock edge.
  - ISSUE: mem_req_valid=1; request fields are driven from the head entry and held stable until mem_req_ready.
  - On handshake (valid && ready): head++, count--. Go to IDLE if the remaining count is 0 after that cycle's enqueues; otherwise stay in ISSUE with the next head entry.
  - Result: back-to-back drain gives one store per cycle when ready is held at 1.
- Latency:
  - Store enqueued at edge N can first appear on mem_req at cycle N+1; there is no bypass from ret_* to mem_req.
  - Handshake in cycle N gives done_valid=1 and done_pos=that entry's pos in cycle N+1, for exactly one cycle.
- Simultaneous enqueue and handshake:
  - count_next = count + accepted - 1.
  - The slot freed in cycle N is not counted in that cycle's space check; it becomes available at N+1 through wb_free.
- Wrap-around: head and tail wrap modulo WB_DEPTH; full is count==WB_DEPTH.
- Lane shaping:
  - mem_req_addr = addr & ~3.
  - BYTE: be = 4'b0001 << addr[1:0]; data = data[7:0] << 8*addr[1:0].
  - HALF: be = 4'b0011 << 2*addr[1]; data = data[15:0] << 16*addr[1]; addr[0] is ignored.
  - WORD: be = 4'b1111; data = data unchanged; addr[1:0] are ignored.
- wb_empty = (count==0) && !mem_req_valid.

Optional Feature:
- Macro: STORE_WB_FWD_EN.
- Defined: adds a load lookup port with inputs ld_valid(1), ld_addr(XLEN), ld_size(2) and outputs ld_hit(1), ld_data(XLEN), all combinational.
  - Searches every valid entry; the newest entry covering all bytes of the load in the same word wins.
  - ld_data holds the covered bytes right-aligned, zero-extended.
  - Partial coverage by the newest overlapping entry forces ld_hit=0.
- Undefined: these ports and this logic do not exist.

Test Plan:
- Reset, then lane0 BYTE addr 0x1003 data 0xAB pos 3 with ready=1 -> next cycle mem_req_addr=0x1000, be=1000, data=0xAB000000; following cycle done_valid=1, done_pos=3.
- 2 lanes per cycle for 4 cycles with ready=0 -> wb_free 8,6,4,2,0, overflow=0; release ready -> 8 back-to-back requests in order with positions 1..8 and done pulses on consecutive cycles.
- Full FIFO plus one extra valid lane -> extra store dropped, overflow=1 until reset, wb_free stays 0.
- ready toggling 0/1 while HALF addr 0x2002 data 0x1234 pending -> request fields stable while ready=0; be=1100, data=0x12340000.
- Assert reset while ISSUE with 3 entries -> next cycle mem_req_valid=0, wb_free=8, no done pulse.
- With STORE_WB_FWD_EN: WORD store 0xDEADBEEF at 0x40 queued, ld BYTE 0x41 -> ld_hit=1, ld_data=0xBE; ld WORD 0x44 -> ld_hit=0.
